// File: rtl/gate_input_debounce_if.sv
// Signal bundle between a raw two-channel source and the debouncer that
// feeds a two-input gate. The master side drives the raw lines and observes
// the conditioned levels; the slave side is the debouncer itself.
interface gate_input_debounce_if;
    logic in1_raw;
    logic in2_raw;
    logic in1;
    logic in2;
    logic chg;
    logic in1_rise;
    logic in1_fall;
    logic in2_rise;
    logic in2_fall;

    modport master (
        output in1_raw, in2_raw,
        input  in1, in2, chg, in1_rise, in1_fall, in2_rise, in2_fall
    );

    modport slave (
        input  in1_raw, in2_raw,
        output in1, in2, chg, in1_rise, in1_fall, in2_rise, in2_fall
    );
endinterface

// File: rtl/gate_input_debounce.sv
// Two-channel input conditioner: each raw line is synchronized with two
// flops, then debounced by a STABLE/PEND state machine. A new level is
// accepted only after it has held for DEBOUNCE_CYCLES synchronized cycles.
// chg pulses for one cycle after either debounced level changes.
// Optional macro GATE_IN_EDGE_STROBE_EN builds registered per-edge pulses
// (in1_rise/in1_fall/in2_rise/in2_fall); without it those ports are tied 0.
module gate_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_input_debounce_if.slave bus
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_e;

    // Count value at which a pending level has held long enough.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    logic [1:0] out_w;
    logic [1:0] accept_w;

    assign raw = {bus.in2_raw, bus.in1_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             sync1_q;
        logic             s_q;
        logic             out_q;
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             accept;

        // Two-flop synchronizer; only s_q is used downstream.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value and the chain really is two stages deep.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_q <= 1'b0;
                s_q     <= 1'b0;
            end else begin
                sync1_q <= raw[ch];
                s_q     <= sync1_q;
            end
        end

        // The counter is 0 while STABLE, so one compare covers both the
        // immediate accept when DEBOUNCE_CYCLES == 1 and the end of a PEND run.
        assign accept = (s_q != out_q) && (cnt_q == CNT_LAST);

        // Debounce FSM: a differing level must hold DEBOUNCE_CYCLES cycles;
        // any return to the current level abandons the count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
            end else begin
                case (state_q)
                    ST_STABLE: begin
                        if (s_q != out_q) begin
                            if (accept) begin
                                out_q <= s_q;
                            end else begin
                                state_q <= ST_PEND;
                                cnt_q   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_PEND: begin
                        if (s_q == out_q) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (accept) begin
                            out_q   <= s_q;
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign out_w[ch]    = out_q;
        assign accept_w[ch] = accept;
    end

    logic chg_q;

    // One change pulse per edge, even when both channels accept together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q <= 1'b0;
        end else begin
            chg_q <= |accept_w;
        end
    end

    assign bus.in1 = out_w[0];
    assign bus.in2 = out_w[1];
    assign bus.chg = chg_q;

`ifdef GATE_IN_EDGE_STROBE_EN
    logic [1:0] rise_q;
    logic [1:0] fall_q;

    // An accept always flips the level, so the current level gives direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= accept_w & ~out_w;
            fall_q <= accept_w &  out_w;
        end
    end

    assign bus.in1_rise = rise_q[0];
    assign bus.in1_fall = fall_q[0];
    assign bus.in2_rise = rise_q[1];
    assign bus.in2_fall = fall_q[1];
`else
    assign bus.in1_rise = 1'b0;
    assign bus.in1_fall = 1'b0;
    assign bus.in2_rise = 1'b0;
    assign bus.in2_fall = 1'b0;
`endif

endmodule

// File: tb/tb_gate_input_debounce.sv
// Bench for gate_input_debounce: one instance with DEBOUNCE_CYCLES=4 and one
// with DEBOUNCE_CYCLES=1. Stimulus pushes the expected chg event (edge
// number, levels, strobes) into a per-instance queue; monitors pop and
// compare whenever chg is seen, and require quiet strobes otherwise.
module tb_gate_input_debounce;

    typedef struct {
        int   cyc;
        logic [5:0] outs;   // {in1, in2, in1_rise, in1_fall, in2_rise, in2_fall}
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    gate_input_debounce_if if_a ();
    gate_input_debounce_if if_b ();

    gate_input_debounce #(.DEBOUNCE_CYCLES(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a)
    );

    gate_input_debounce #(.DEBOUNCE_CYCLES(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter: at a falling edge it equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Builds an expected event; strobes only exist when the macro is defined.
    function automatic exp_t mk(input int c, input logic i1, input logic i2,
                                input logic r1, input logic f1,
                                input logic r2, input logic f2);
        exp_t e;
        e.cyc = c;
`ifdef GATE_IN_EDGE_STROBE_EN
        e.outs = {i1, i2, r1, f1, r2, f2};
`else
        e.outs = {i1, i2, 4'b0000 & {r1, f1, r2, f2}};
`endif
        return e;
    endfunction

    function automatic logic [5:0] outs_a();
        return {if_a.in1, if_a.in2, if_a.in1_rise, if_a.in1_fall, if_a.in2_rise, if_a.in2_fall};
    endfunction

    function automatic logic [5:0] outs_b();
        return {if_b.in1, if_b.in2, if_b.in1_rise, if_b.in1_fall, if_b.in2_rise, if_b.in2_fall};
    endfunction

    // Monitor for the DEBOUNCE_CYCLES=4 instance.
    always @(negedge clk) begin
        exp_t e;
        if (if_a.chg) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_chg: got chg=1 expected no event (edge %0d)", cyc);
            end else begin
                e = q_a.pop_front();
                check("a_event_edge", cyc, e.cyc);
                check("a_event_outs", outs_a(), e.outs);
            end
        end else begin
            check("a_idle_strobes", outs_a() & 6'b001111, 0);
        end
    end

    // Monitor for the DEBOUNCE_CYCLES=1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (if_b.chg) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_chg: got chg=1 expected no event (edge %0d)", cyc);
            end else begin
                e = q_b.pop_front();
                check("b_event_edge", cyc, e.cyc);
                check("b_event_outs", outs_b(), e.outs);
            end
        end else begin
            check("b_idle_strobes", outs_b() & 6'b001111, 0);
        end
    end

    initial begin
        rst_n        = 1'b0;
        if_a.in1_raw = 1'b1;
        if_a.in2_raw = 1'b1;
        if_b.in1_raw = 1'b0;
        if_b.in2_raw = 1'b0;

        // Reset with raw inputs high: everything reads 0.
        repeat (3) @(negedge clk);
        check("rst_a_levels", {if_a.in1, if_a.in2}, 0);
        check("rst_a_chg", if_a.chg, 0);
        check("rst_a_strobes", outs_a() & 6'b001111, 0);
        check("rst_b_outs", {outs_b(), if_b.chg}, 0);

        // Release: high raws are new levels, accepted at edge 5 after release.
        rst_n = 1'b1;
        q_a.push_back(mk(cyc + 6, 1, 1, 1, 0, 1, 0));
        repeat (10) @(negedge clk);
        check("a_levels_after_reset", {if_a.in1, if_a.in2}, 2'b11);

        // Simultaneous fall on both channels: one chg, both fall strobes.
        if_a.in1_raw = 1'b0;
        if_a.in2_raw = 1'b0;
        q_a.push_back(mk(cyc + 6, 0, 0, 0, 1, 0, 1));
        repeat (10) @(negedge clk);

        // Clean step on channel 1, channel 2 untouched.
        if_a.in1_raw = 1'b1;
        q_a.push_back(mk(cyc + 6, 1, 0, 1, 0, 0, 0));
        repeat (10) @(negedge clk);
        check("a_step_levels", {if_a.in1, if_a.in2}, 2'b10);
        if_a.in1_raw = 1'b0;
        q_a.push_back(mk(cyc + 6, 0, 0, 0, 1, 0, 0));
        repeat (10) @(negedge clk);

        // Bounce on channel 2: high 3, low 1, then high and holding.
        if_a.in2_raw = 1'b1;
        repeat (3) @(negedge clk);
        if_a.in2_raw = 1'b0;
        @(negedge clk);
        if_a.in2_raw = 1'b1;
        q_a.push_back(mk(cyc + 6, 0, 1, 0, 0, 1, 0));
        repeat (5) @(negedge clk);
        check("a_bounce_held", if_a.in2, 0);
        repeat (8) @(negedge clk);
        check("a_bounce_accepted", if_a.in2, 1);
        if_a.in2_raw = 1'b0;
        q_a.push_back(mk(cyc + 6, 0, 0, 0, 0, 0, 1));
        repeat (10) @(negedge clk);

        // Reset three edges into a count: count restarts after release.
        if_a.in1_raw = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("a_midcount_rst_in1", if_a.in1, 0);
        check("a_midcount_rst_chg", if_a.chg, 0);
        rst_n = 1'b1;
        q_a.push_back(mk(cyc + 6, 1, 0, 1, 0, 0, 0));
        repeat (10) @(negedge clk);
        if_a.in1_raw = 1'b0;
        q_a.push_back(mk(cyc + 6, 0, 0, 0, 1, 0, 0));
        repeat (10) @(negedge clk);

        // DEBOUNCE_CYCLES=1: a one-cycle raw pulse reaches in1 three edges later.
        if_b.in1_raw = 1'b1;
        q_b.push_back(mk(cyc + 3, 1, 0, 1, 0, 0, 0));
        @(negedge clk);
        if_b.in1_raw = 1'b0;
        q_b.push_back(mk(cyc + 3, 0, 0, 0, 1, 0, 0));
        repeat (8) @(negedge clk);
        if_b.in1_raw = 1'b1;
        if_b.in2_raw = 1'b1;
        q_b.push_back(mk(cyc + 3, 1, 1, 1, 0, 1, 0));
        repeat (8) @(negedge clk);
        check("b_both_high", {if_b.in1, if_b.in2}, 2'b11);

        // Bounded drain: any event still queued was never produced.
        for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_input_debounce.md
# gate_input_debounce

Two-channel input conditioner that sits directly upstream of the team's two-input logic gates (NOR, NAND and similar). It takes raw, asynchronous, possibly bouncing `in1_raw`/`in2_raw` signals, such as switches or off-chip lines, and synchronizes each one to `clk`. It then debounces each channel and drives clean, glitch-free `in1`/`in2` levels that connect straight to a gate's `in1`/`in2` ports. It also flags every accepted level change.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized cycles a new level must hold before it is accepted. Legal range 1..65535.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: width of the counter. Derived; never overridden.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in1_raw`, input, 1: raw channel 1, asynchronous to `clk`.
- `in2_raw`, input, 1: raw channel 2, asynchronous to `clk`.
- `in1`, output, 1: debounced channel 1 level.
- `in2`, output, 1: debounced channel 2 level.
- `chg`, output, 1: one-cycle pulse when `in1` or `in2` changed on this edge.
- `in1_rise`, `in1_fall`, `in2_rise`, `in2_fall`, output, 1 each: per-edge pulses. Tied 0 unless the macro in Configuration is defined.

## Operation
- Each channel is independent and identical.
- Each channel has a 2-flop synchronizer: `sync1 <= raw`, then `s <= sync1`. Only `s` is used downstream.
- Each channel has a two-state FSM.
  - STABLE: `s == out`; counter held at 0.
  - PEND: `s != out`; counter counts.
- STABLE to PEND: on an edge where `s != out`. Counter goes 0 to 1, or straight to accept if `DEBOUNCE_CYCLES == 1`.
- PEND to PEND: `s != out` and counter < `DEBOUNCE_CYCLES-1`; counter increments.
- PEND to STABLE (accept): `s != out` and counter == `DEBOUNCE_CYCLES-1`. Then `out <= s`, counter goes to 0, and the change pulse fires on the following cycle.
- PEND to STABLE (reject bounce): `s == out`. Counter goes to 0 and `out` is unchanged.
- The counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- `chg` is the registered OR of both channels' accept events.
  - Both channels accepting on the same edge produce a single `chg` pulse.
- Reset (`rst_n` low, at any time, including mid-count) asynchronously clears:
  - all synchronizer flops;
  - the counters, and returns both FSMs to STABLE;
  - outputs: `in1`=0, `in2`=0, `chg`=0, all rise/fall pulses 0.
- After reset release, a raw input already at 1 is treated as a new level. It is debounced normally and accepted after the full latency.

## Timing
- Latency from a raw change (stable from edge 0) to the output changing: `DEBOUNCE_CYCLES+2` rising edges.
  - Edges 0–1 are the synchronizer.
  - With the default of 4, the output updates at edge 5.
- `chg` and the rise/fall pulses are high for exactly the one cycle after `in1`/`in2` updates, and 0 otherwise.
- A raw pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles never reaches the output.
- Minimum spacing between two accepted changes on one channel: `DEBOUNCE_CYCLES` cycles.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- Macro `GATE_IN_EDGE_STROBE_EN`.
- Defined: the four per-edge outputs are registered.
  - `inX_rise` pulses one cycle when `inX` goes 0 to 1.
  - `inX_fall` pulses one cycle when `inX` goes 1 to 0.
  - These pulses are aligned with `chg`.
- Undefined: the four ports remain present and are driven constant 0. No flops are built for them.
- `chg` and `in1`/`in2` behave the same either way.

## Test plan
All cases use `DEBOUNCE_CYCLES`=4 unless stated otherwise.
- Reset check: hold `rst_n`=0 with `in1_raw`=`in2_raw`=1. All outputs read 0. Release reset, then `in1`=`in2`=1 at edge 5 after release, with a single `chg` pulse on the next cycle.
- Clean step: `in1_raw` goes 0 to 1 before edge 0 and holds. `in1`=1 at edge 5; `chg`=1 and `in1_rise`=1 for exactly one cycle (macro on); `in2` stays 0.
- Bounce rejection: `in2_raw` is high for 3 cycles, low for 1 cycle, then high and holding. `in2` does not change during the bounce. It goes to 1 only 4 synchronized cycles after the last rising edge, with one `chg` pulse.
- Simultaneous change: both raws go 1 to 0 on the same cycle. `in1` and `in2` fall on the same edge; `chg` pulses once; `in1_fall` and `in2_fall` both pulse.
- Reset mid-count: `in1_raw` goes high and `rst_n` is pulsed low after 3 edges. `in1` stays 0, and the count restarts from zero after release.
- Parameter edge case, `DEBOUNCE_CYCLES`=1: a 1-cycle raw pulse reaches `in1` 3 edges later. With the macro off, all rise/fall outputs stay 0 throughout.
